// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 sizes, FSM states, fault codes
// and the two capture-time legality checks.
package lsu_pkg;

  localparam int unsigned DEFAULT_TIMEOUT = 16;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_REQ   = 2'b01,
    ST_DONE  = 2'b10,
    ST_FAULT = 2'b11
  } lsu_state_e;

  typedef enum logic [1:0] {
    FLT_OK       = 2'b00,
    FLT_MISALIGN = 2'b01,
    FLT_ILLEGAL  = 2'b10,
    FLT_TIMEOUT  = 2'b11
  } fault_e;

  // Unsigned sizes only exist for loads.
  function automatic logic f3_illegal(input logic [2:0] f3, input logic is_store);
    logic bad;
    case (f3)
      F3_B, F3_H, F3_W: bad = 1'b0;
      F3_BU, F3_HU:     bad = is_store;
      default:          bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic mis;
    case (f3)
      F3_H, F3_HU: mis = addr_lo[0];
      F3_W:        mis = (addr_lo != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: store byte enables and data replication, plus
// load lane selection with sign or zero extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_is_store,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_value
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    // NOTE: every output gets a default first so no path through the cases can infer a latch.
    w_byte       = i_rdata[7:0];
    w_half       = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_be         = 4'b1111;
    o_wdata      = i_store_data;
    o_load_value = i_rdata;

    case (i_addr_lo)
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase

    if (i_is_store) begin
      case (i_funct3)
        F3_B: begin
          o_be    = 4'b0001 << i_addr_lo;
          o_wdata = {4{i_store_data[7:0]}};
        end
        F3_H: begin
          o_be    = 4'b0011 << {i_addr_lo[1], 1'b0};
          o_wdata = {2{i_store_data[15:0]}};
        end
        default: begin
          o_be    = 4'b1111;
          o_wdata = i_store_data;
        end
      endcase
    end

    case (i_funct3)
      F3_B:    o_load_value = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load_value = {24'd0, w_byte};
      F3_H:    o_load_value = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load_value = {16'd0, w_half};
      default: o_load_value = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between the core control path and a
// request/ack data memory; all outputs are registered.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic [1:0]  fault,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  lsu_state_e  r_state;
  lsu_state_e  w_next;

  logic          r_op_store;
  logic [2:0]    r_funct3;
  logic [1:0]    r_addr_lo;
  logic [CW-1:0] r_tmo_cnt;

  logic        r_busy;
  logic        r_done;
  logic [31:0] r_load_data;
  fault_e      r_fault;
  logic        r_dmem_req;
  logic        r_dmem_we;
  logic [31:0] r_dmem_addr;
  logic [31:0] r_dmem_wdata;
  logic [3:0]  r_dmem_be;

  logic        w_start_ok;
  logic        w_illegal;
  logic        w_misaligned;
  logic        w_timeout;
  logic        w_in_idle;
  logic [2:0]  w_al_funct3;
  logic [1:0]  w_al_addr_lo;
  logic        w_al_store;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load_value;

  assign w_start_ok   = start & (mem_read ^ mem_write);
  assign w_illegal    = f3_illegal(funct3, mem_write);
  assign w_misaligned = f3_misaligned(funct3, addr[1:0]);
  assign w_timeout    = (r_tmo_cnt == CW'(TIMEOUT - 1));
  assign w_in_idle    = (r_state == ST_IDLE);

  // In IDLE the aligner sees the live request so enables/data are ready on REQ entry;
  // afterwards it sees the captured size and lane for load extraction.
  assign w_al_funct3  = w_in_idle ? funct3    : r_funct3;
  assign w_al_addr_lo = w_in_idle ? addr[1:0] : r_addr_lo;
  assign w_al_store   = w_in_idle ? mem_write : r_op_store;

  lsu_lane_align u_align (
    .i_funct3     (w_al_funct3),
    .i_addr_lo    (w_al_addr_lo),
    .i_is_store   (w_al_store),
    .i_store_data (store_data),
    .i_rdata      (dmem_rdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_load_value (w_load_value)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) begin
          w_next = (w_illegal || w_misaligned) ? ST_FAULT : ST_REQ;
        end
      end
      ST_REQ: begin
        if (dmem_ack || w_timeout) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE:  w_next = ST_IDLE;
      ST_FAULT: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op_store   <= 1'b0;
      r_funct3     <= 3'b000;
      r_addr_lo    <= 2'b00;
      r_tmo_cnt    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_load_data  <= 32'd0;
      r_fault      <= FLT_OK;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= 32'd0;
      r_dmem_wdata <= 32'd0;
      r_dmem_be    <= 4'b0000;
    end else begin
      r_busy     <= (w_next != ST_IDLE);
      r_done     <= (w_next == ST_DONE) || (w_next == ST_FAULT);
      r_dmem_req <= (w_next == ST_REQ);
      r_fault    <= FLT_OK;

      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_op_store <= mem_write;
            r_funct3   <= funct3;
            r_addr_lo  <= addr[1:0];
            r_tmo_cnt  <= '0;
            if (w_illegal) begin
              r_fault <= FLT_ILLEGAL;
            end else if (w_misaligned) begin
              r_fault <= FLT_MISALIGN;
            end else begin
              r_dmem_we    <= mem_write;
              r_dmem_addr  <= {addr[31:2], 2'b00};
              r_dmem_wdata <= w_wdata;
              r_dmem_be    <= w_be;
            end
          end
        end
        ST_REQ: begin
          if (dmem_ack) begin
            if (!r_op_store) begin
              r_load_data <= w_load_value;
            end
          end else if (w_timeout) begin
            r_fault     <= FLT_TIMEOUT;
            r_load_data <= 32'd0;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign load_data  = r_load_data;
  assign fault      = r_fault;
  assign dmem_req   = r_dmem_req;
  assign dmem_we    = r_dmem_we;
  assign dmem_addr  = r_dmem_addr;
  assign dmem_wdata = r_dmem_wdata;
  assign dmem_be    = r_dmem_be;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads of every size, stores with wait
// states, capture faults, timeout abort and mid-transaction reset.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'd0;
  logic [31:0] store_data = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic [1:0]  fault;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;

  int n_tests = 0;
  int n_fail  = 0;

  load_store_unit #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .busy       (busy),
    .done       (done),
    .load_data  (load_data),
    .fault      (fault),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_be    (dmem_be),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives a one-cycle start; returns sampling cycle 1 of the transaction.
  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    start = 1'b1; mem_read = rd; mem_write = wr;
    funct3 = f3; addr = a; store_data = d;
    tick();
    start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic load_ack1(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] rdata, input logic [31:0] exp);
    issue(1'b1, 1'b0, f3, a, 32'd0);
    dmem_ack = 1'b1; dmem_rdata = rdata;
    tick();
    dmem_ack = 1'b0;
    check({tag, "_done"}, done, 1);
    check({tag, "_data"}, load_data, exp);
    tick();
  endtask

  task automatic fault_case(input string tag, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] a,
                            input logic [1:0] exp_fault, input logic [31:0] held);
    issue(rd, wr, f3, a, 32'h1234_5678);
    check({tag, "_done"}, done, 1);
    check({tag, "_fault"}, fault, exp_fault);
    check({tag, "_req"}, dmem_req, 0);
    check({tag, "_ld"}, load_data, held);
    tick();
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int req_cnt;
    int done_cnt;
    logic got_done;
    logic [1:0]  seen_fault;
    logic [31:0] seen_ld;

    repeat (3) tick();
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fault", fault, 0);
    check("rst_req", dmem_req, 0);
    check("rst_addr", dmem_addr, 0);
    check("rst_be", dmem_be, 0);
    check("rst_ld", load_data, 0);

    // LW 0x100, ack in cycle 1, done in cycle 2; start in DONE is ignored.
    issue(1'b1, 1'b0, 3'b010, 32'h100, 32'd0);
    check("lw_req", dmem_req, 1);
    check("lw_we", dmem_we, 0);
    check("lw_addr", dmem_addr, 32'h100);
    check("lw_be", dmem_be, 4'b1111);
    check("lw_busy", busy, 1);
    check("lw_c1_done", done, 0);
    dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    tick();
    dmem_ack = 1'b0;
    check("lw_done", done, 1);
    check("lw_data", load_data, 32'hDEAD_BEEF);
    check("lw_fault", fault, 0);
    check("lw_req_drop", dmem_req, 0);
    start = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h200;
    tick();
    start = 1'b0; mem_read = 1'b0;
    check("done_start_ign_busy", busy, 0);
    check("done_start_ign_done", done, 0);
    tick();
    check("done_start_ign_req", dmem_req, 0);

    load_ack1("lb",  3'b000, 32'h103, 32'h8012_3456, 32'hFFFF_FF80);
    load_ack1("lbu", 3'b100, 32'h103, 32'h8012_3456, 32'h0000_0080);
    load_ack1("lh",  3'b001, 32'h102, 32'h8012_3456, 32'hFFFF_8012);
    load_ack1("lhu", 3'b101, 32'h102, 32'h8012_3456, 32'h0000_8012);
    load_ack1("lb0", 3'b000, 32'h100, 32'h8012_3456, 32'h0000_0056);

    // SB 0x0A, ack after three wait cycles.
    issue(1'b0, 1'b1, 3'b000, 32'h0A, 32'h0000_00AB);
    check("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
    check("sb_be", dmem_be, 4'b0100);
    check("sb_we", dmem_we, 1);
    check("sb_addr", dmem_addr, 32'h08);
    req_cnt = 0; done_cnt = 0;
    for (int i = 1; i <= 7; i++) begin
      dmem_ack = (i == 4);
      if (dmem_req) req_cnt++;
      if (done) done_cnt++;
      tick();
    end
    dmem_ack = 1'b0;
    check("sb_req_cycles", req_cnt, 4);
    check("sb_done_cnt", done_cnt, 1);
    check("sb_ld_held", load_data, 32'h0000_0056);

    // SH 0x02 replicates the halfword into the upper lane pair.
    issue(1'b0, 1'b1, 3'b001, 32'h2, 32'hFFFF_1234);
    check("sh_wdata", dmem_wdata, 32'h1234_1234);
    check("sh_be", dmem_be, 4'b1100);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    check("sh_done", done, 1);
    tick();

    fault_case("lw_mis",  1'b1, 1'b0, 3'b010, 32'h06,  2'b01, 32'h0000_0056);
    fault_case("lh_mis",  1'b1, 1'b0, 3'b001, 32'h101, 2'b01, 32'h0000_0056);
    fault_case("f3_011",  1'b1, 1'b0, 3'b011, 32'h100, 2'b10, 32'h0000_0056);
    fault_case("sbu_ill", 1'b0, 1'b1, 3'b100, 32'h100, 2'b10, 32'h0000_0056);
    fault_case("prio",    1'b0, 1'b1, 3'b101, 32'h101, 2'b10, 32'h0000_0056);

    // Start with both or neither op qualifier is ignored.
    issue(1'b1, 1'b1, 3'b010, 32'h100, 32'd0);
    check("both_busy", busy, 0);
    check("both_req", dmem_req, 0);
    issue(1'b0, 1'b0, 3'b010, 32'h100, 32'd0);
    check("none_busy", busy, 0);

    // Timeout with no ack.
    issue(1'b1, 1'b0, 3'b010, 32'h200, 32'd0);
    req_cnt = 0; got_done = 1'b0; seen_fault = 2'b00; seen_ld = 32'hFFFF_FFFF;
    for (int i = 0; i < 40 && !got_done; i++) begin
      if (dmem_req) req_cnt++;
      if (done) begin
        got_done = 1'b1; seen_fault = fault; seen_ld = load_data;
      end else begin
        tick();
      end
    end
    check("tmo_done_seen", got_done, 1);
    check("tmo_req_cycles", req_cnt, 16);
    check("tmo_fault", seen_fault, 2'b11);
    check("tmo_ld", seen_ld, 32'd0);
    check("tmo_req_drop", dmem_req, 0);
    tick();

    // Reset during REQ wait cycle 2; a second start while busy is ignored.
    issue(1'b1, 1'b0, 3'b010, 32'h300, 32'd0);
    start = 1'b1; mem_write = 1'b1; funct3 = 3'b000; addr = 32'h404; store_data = 32'h77;
    tick();
    start = 1'b0; mem_write = 1'b0;
    check("busy_ign_addr", dmem_addr, 32'h300);
    check("busy_ign_we", dmem_we, 0);
    check("busy_ign_req", dmem_req, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_req", dmem_req, 0);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_fault", fault, 0);
    check("mrst_we", dmem_we, 0);
    check("mrst_addr", dmem_addr, 0);
    check("mrst_wdata", dmem_wdata, 0);
    check("mrst_be", dmem_be, 0);
    check("mrst_ld", load_data, 0);
    tick();
    check("mrst_no_done", done, 0);

    load_ack1("post_rst", 3'b010, 32'h10, 32'hCAFE_F00D, 32'hCAFE_F00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT, default 16: cycles in REQ without dmem_ack before abort.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request from control; sampled only in IDLE.
REQ-005 mem_read  input  1  load request; qualifies start.
REQ-006 mem_write  input  1  store request; qualifies start.
REQ-007 funct3  input  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
REQ-008 addr  input  32  byte address from ALU result.
REQ-009 store_data  input  32  store operand from register-bank Data2.
REQ-010 busy  output  1  high whenever state is not IDLE; drives PC enable low (stall).
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 load_data  output  32  extended load result; held until next done.
REQ-013 fault  output  2  00 ok, 01 misaligned, 10 illegal funct3, 11 timeout; valid with done.
REQ-014 dmem_req  output  1  memory request, held until dmem_ack.
REQ-015 dmem_we  output  1  1 = write access.
REQ-016 dmem_addr  output  32  word address {addr[31:2],2'b00}.
REQ-017 dmem_wdata  output  32  lane-replicated store data.
REQ-018 dmem_be  output  4  byte enables.
REQ-019 dmem_ack  input  1  memory accepted write / rdata valid this cycle.
REQ-020 dmem_rdata  input  32  read word.

Function
REQ-021 FSM states IDLE, REQ, DONE, FAULT; all outputs registered.
REQ-022 IDLE: start with exactly one of mem_read/mem_write captures addr, store_data, funct3, op; start with both or neither is ignored, state stays IDLE.
REQ-023 Capture checks: illegal funct3 (011, 11x, or 100/101 with store) -> FAULT code 10; H at addr[0]=1 or W at addr[1:0]!=0 -> FAULT code 01; illegal takes priority; otherwise -> REQ.
REQ-024 FAULT lasts one cycle: done=1, fault set, load_data unchanged, dmem_req never asserted; then IDLE.
REQ-025 REQ: dmem_req=1, dmem_we=op, dmem_addr/wdata/be stable until ack; ack in first REQ cycle is legal.
REQ-026 Byte enables: B 4'b0001<<addr[1:0]; H 4'b0011<<{addr[1],1'b0}; W 4'b1111; loads drive all four.
REQ-027 Write data: B {4{d[7:0]}}, H {2{d[15:0]}}, W d.
REQ-028 On ack for load: select lane by addr[1:0], sign-extend (B/H) or zero-extend (BU/HU), register into load_data; go DONE.
REQ-029 Stores leave load_data unchanged.
REQ-030 Timeout counter resets on REQ entry; after TIMEOUT cycles without ack -> DONE with fault=11, dmem_req dropped, load_data=0.
REQ-031 DONE lasts one cycle: done=1, fault 00 (or 11), dmem_req=0; then IDLE; start in DONE ignored.
REQ-032 Latency: start at cycle 0, ack at cycle k>=1 -> done at cycle k+1; fault -> done at cycle 1.
REQ-033 start while busy ignored, never queued.

Reset
REQ-034 reset -> IDLE; busy, done, fault, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, load_data, timeout counter all 0.
REQ-035 Reset mid-transaction abandons it: dmem_req low from the reset edge, no done pulse.

Structure
REQ-036 Package lsu_pkg holds funct3 encodings, state encoding, fault codes, default TIMEOUT.
REQ-037 Sub-module lsu_lane_align: combinational byte-enable/write-replication and load lane-select/extend.

Verification
REQ-038 LW addr 0x100, ack cycle 1, rdata 0xDEADBEEF -> dmem_addr 0x100, be 1111, done cycle 2, load_data 0xDEADBEEF, fault 00.
REQ-039 LB addr 0x103, rdata 0x80123456 -> load_data 0xFFFFFF80; LBU same -> 0x00000080; LH addr 0x102 -> 0xFFFF8012.
REQ-040 SB addr 0x0A, store_data 0x000000AB, ack after 3 wait cycles -> wdata 0xABABABAB, be 0100, req held 4 cycles, done once.
REQ-041 LW addr 0x06 -> fault 01 cycle 1, no dmem_req; funct3 011 -> fault 10.
REQ-042 LW, no ack, TIMEOUT=16 -> req high 16 cycles, done with fault 11, load_data 0.
REQ-043 reset asserted in REQ wait cycle 2 -> next cycle all outputs 0, IDLE, no done; second start during busy ignored.
